// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C line-conditioning stage and its consumers.
// The bus-event encoding lets the master/slave FSMs see the last decoded
// bus event as a single value instead of three separate strobes.
package i2c_pkg;

    localparam int I2C_FILTER_LEN_DEFAULT = 4;
    localparam int I2C_TIMEOUT_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_START,
        EV_RSTART,
        EV_STOP
    } i2c_bus_event_t;

    // True for either kind of START.
    function automatic logic ev_is_start(input i2c_bus_event_t ev);
        return (ev == EV_START) || (ev == EV_RSTART);
    endfunction

endpackage

// File: rtl/i2c_bus_monitor_if.sv
// Bundle between the bus monitor and the master/slave FSMs.
// The slave modport is the monitor's view: it consumes the synchronized
// lines and the registered drive values, and produces the conditioned
// lines, edge strobes, bus events and status.  The master modport is the
// opposite side (the block feeding and consuming the monitor).
// Strobes (scl_rise, scl_fall, start_det, rstart_det, stop_det, arb_lost,
// bus_timeout) are valid for exactly one clk cycle with no handshake: the
// consumer must sample them every cycle, there is no ready/back-pressure.
interface i2c_bus_monitor_if #(
    parameter int TIMEOUT_W = i2c_pkg::I2C_TIMEOUT_W_DEFAULT
);

    // Inputs to the monitor
    logic                  SDA_sync;
    logic                  SCL_sync;
    logic                  SDA_out;
    logic                  SCL_out;
    logic                  master_active;
    logic [TIMEOUT_W-1:0]  timeout_limit;

    // Outputs from the monitor
    logic                  SDA_filt;
    logic                  SCL_filt;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_det;
    logic                  rstart_det;
    logic                  stop_det;
    logic                  bus_busy;
    logic                  arb_lost;
    logic                  scl_stretch;
    logic                  bus_timeout;
    i2c_pkg::i2c_bus_event_t bus_event;

    modport slave (
        input  SDA_sync,
        input  SCL_sync,
        input  SDA_out,
        input  SCL_out,
        input  master_active,
        input  timeout_limit,
        output SDA_filt,
        output SCL_filt,
        output scl_rise,
        output scl_fall,
        output start_det,
        output rstart_det,
        output stop_det,
        output bus_busy,
        output arb_lost,
        output scl_stretch,
        output bus_timeout,
        output bus_event
    );

    modport master (
        output SDA_sync,
        output SCL_sync,
        output SDA_out,
        output SCL_out,
        output master_active,
        output timeout_limit,
        input  SDA_filt,
        input  SCL_filt,
        input  scl_rise,
        input  scl_fall,
        input  start_det,
        input  rstart_det,
        input  stop_det,
        input  bus_busy,
        input  arb_lost,
        input  scl_stretch,
        input  bus_timeout,
        input  bus_event
    );

endinterface

// File: rtl/i2c_glitch_filter.sv
// Single-line glitch filter with edge strobes.
// The filtered value only follows the raw line after FILTER_LEN consecutive
// cycles of disagreement; any agreeing cycle restarts the count, so pulses
// shorter than FILTER_LEN cycles are swallowed.  rise/fall compare the
// filtered value against a one-cycle-delayed copy, so they are high during
// the single cycle in which the new filtered value first appears.
module i2c_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw,
    output logic filt,
    output logic rise,
    output logic fall
);

    // FILTER_LEN is limited to 1..15, so four bits always hold the count.
    localparam int          CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             filt_dly_q;

    // Next-state: count disagreeing cycles, flip the filtered value on the last one.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (raw != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = raw;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; an idle I2C line is high, so reset to 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q      <= '0;
            filt_q     <= 1'b1;
            filt_dly_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
        end
    end

    assign filt = filt_q;
    assign rise = filt_q & ~filt_dly_q;
    assign fall = ~filt_q & filt_dly_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: filters SDA/SCL, derives SCL edge strobes, decodes
// START / repeated START / STOP, tracks bus ownership, and flags
// arbitration loss, clock stretching and SCL-low timeout.
// START/STOP are only recognised while SCL has been high for at least one
// full cycle (SCL_filt high and not just risen), which also rejects the
// case where SDA and SCL change in the same cycle.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = I2C_FILTER_LEN_DEFAULT,
    parameter int TIMEOUT_W  = I2C_TIMEOUT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             n_rst,
    i2c_bus_monitor_if.slave bus
);

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    logic sda_filt, sda_rise, sda_fall;
    logic scl_filt, scl_rise, scl_fall;

    i2c_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sda_filter (
        .clk   (clk),
        .n_rst (n_rst),
        .raw   (bus.SDA_sync),
        .filt  (sda_filt),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    i2c_glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_scl_filter (
        .clk   (clk),
        .n_rst (n_rst),
        .raw   (bus.SCL_sync),
        .filt  (scl_filt),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    // SCL high now and in the previous cycle.
    logic scl_high_stable;
    assign scl_high_stable = scl_filt & ~scl_rise;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    i2c_bus_event_t       ev_q, ev_d;
    logic                 bus_busy_q, bus_busy_d;
    logic                 stretch_q, stretch_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic                 tmo_counting;
    logic                 tmo_hit;
    logic                 arb_scl;
    logic                 arb_event;

    // Event decode: an SDA edge during a stable-high SCL is START or STOP.
    always_comb begin
        ev_d = EV_NONE;
        if (scl_high_stable) begin
            if (sda_fall) begin
                if (bus_busy_q) begin
                    ev_d = EV_RSTART;
                end else begin
                    ev_d = EV_START;
                end
            end else if (sda_rise) begin
                ev_d = EV_STOP;
            end
        end
    end

    // Timeout counting window and limit compare; a zero limit disables it.
    assign tmo_counting = bus_busy_q & ~scl_filt & (bus.timeout_limit != '0);
    assign tmo_hit      = tmo_counting && (tmo_cnt_q == (bus.timeout_limit - 1'b1));

    // Timeout counter next-state: count while SCL is held low, saturate, clear on hit.
    always_comb begin
        tmo_cnt_d = '0;
        if (tmo_counting && !scl_rise) begin
            if (tmo_hit) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q;
            end
        end
    end

    // Bus ownership: a fresh START claims the bus, STOP or timeout frees it.
    always_comb begin
        bus_busy_d = bus_busy_q;
        if (ev_q == EV_START) begin
            bus_busy_d = 1'b1;
        end else if ((ev_q == EV_STOP) || tmo_hit) begin
            bus_busy_d = 1'b0;
        end
    end

    assign stretch_d = bus.SCL_out & ~scl_filt;

    // Arbitration loss: we released SDA but the bus reads low at SCL rise,
    // or a START/STOP appeared whose SDA level we were not driving.
    assign arb_scl   = scl_rise & bus.SDA_out & ~sda_filt;
    assign arb_event = (ev_d != EV_NONE) & (bus.SDA_out != sda_filt);

    // Register event, busy, stretch and timeout state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ev_q       <= EV_NONE;
            bus_busy_q <= 1'b0;
            stretch_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            ev_q       <= ev_d;
            bus_busy_q <= bus_busy_d;
            stretch_q  <= stretch_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.SDA_filt    = sda_filt;
    assign bus.SCL_filt    = scl_filt;
    assign bus.scl_rise    = scl_rise;
    assign bus.scl_fall    = scl_fall;
    assign bus.start_det   = (ev_q == EV_START);
    assign bus.rstart_det  = (ev_q == EV_RSTART);
    assign bus.stop_det    = (ev_q == EV_STOP);
    assign bus.bus_busy    = bus_busy_q;
    assign bus.arb_lost    = bus.master_active & (arb_scl | arb_event);
    assign bus.scl_stretch = stretch_q;
    assign bus.bus_timeout = tmo_hit;
    assign bus.bus_event   = ev_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for the I2C bus monitor (FILTER_LEN = 4, TIMEOUT_W = 16).
module tb_i2c_bus_monitor;

    logic clk;
    logic n_rst;

    i2c_bus_monitor_if #(.TIMEOUT_W(16)) bus ();

    i2c_bus_monitor #(
        .FILTER_LEN (4),
        .TIMEOUT_W  (16)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int n_rise, n_fall, n_start, n_rstart, n_stop, n_arb, n_timeout;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of all single-bit outputs, reset value is 11'b110_0000_0000
    function automatic logic [10:0] out_vec();
        return {bus.SDA_filt, bus.SCL_filt, bus.scl_rise, bus.scl_fall,
                bus.start_det, bus.rstart_det, bus.stop_det, bus.bus_busy,
                bus.arb_lost, bus.scl_stretch, bus.bus_timeout};
    endfunction

    task automatic clear_counts();
        n_rise = 0; n_fall = 0; n_start = 0; n_rstart = 0;
        n_stop = 0; n_arb = 0; n_timeout = 0;
    endtask

    // One clock; outputs sampled 1 ns after the edge and strobes tallied.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.scl_rise)    n_rise++;
        if (bus.scl_fall)    n_fall++;
        if (bus.start_det)   n_start++;
        if (bus.rstart_det)  n_rstart++;
        if (bus.stop_det)    n_stop++;
        if (bus.arb_lost)    n_arb++;
        if (bus.bus_timeout) n_timeout++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drivers (SCL assumed high on entry)
    task automatic go_start();
        bus.SDA_sync = 1'b0;
        steps(8);
    endtask

    task automatic clock_bit(input logic b);
        bus.SCL_sync = 1'b0;
        steps(4);
        bus.SDA_sync = b;
        steps(4);
        bus.SCL_sync = 1'b1;
        steps(8);
    endtask

    task automatic go_stop();
        clock_bit(1'b0);
        bus.SDA_sync = 1'b1;
        steps(8);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        if (out_vec() !== 11'b110_0000_0000) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", out_vec(), 11'b110_0000_0000);
        end
        checks++;
        n_rst = 1'b1;
        steps(6);
        if (out_vec() !== 11'b110_0000_0000) begin
            errors++; $display("FAIL idle_after_reset: got %b expected %b", out_vec(), 11'b110_0000_0000);
        end
        checks++;
    endtask

    task automatic test_glitch();
        clear_counts();
        bus.SDA_sync = 1'b0;
        steps(3);
        if (bus.SDA_filt !== 1'b1) begin
            errors++; $display("FAIL glitch3_filt: got %b expected 1", bus.SDA_filt);
        end
        checks++;
        bus.SDA_sync = 1'b1;
        steps(6);
        if (n_start !== 0 || bus.bus_busy !== 1'b0) begin
            errors++; $display("FAIL glitch3_no_start: got start=%0d busy=%b expected 0 0", n_start, bus.bus_busy);
        end
        checks++;
        bus.SDA_sync = 1'b0;
        steps(3);
        if (bus.SDA_filt !== 1'b1) begin
            errors++; $display("FAIL low3_filt: got %b expected 1", bus.SDA_filt);
        end
        checks++;
        step();
        if (bus.SDA_filt !== 1'b0 || bus.start_det !== 1'b0) begin
            errors++; $display("FAIL low4_filt: got filt=%b start=%b expected 0 0", bus.SDA_filt, bus.start_det);
        end
        checks++;
        step();
        if (bus.start_det !== 1'b1 || bus.bus_busy !== 1'b0) begin
            errors++; $display("FAIL start_det: got start=%b busy=%b expected 1 0", bus.start_det, bus.bus_busy);
        end
        checks++;
        step();
        if (bus.start_det !== 1'b0 || bus.bus_busy !== 1'b1) begin
            errors++; $display("FAIL busy_set: got start=%b busy=%b expected 0 1", bus.start_det, bus.bus_busy);
        end
        checks++;
    endtask

    // Continues the frame opened by test_glitch.
    task automatic test_frame();
        logic [7:0] data;
        int k;
        data = 8'hA5;
        for (int i = 7; i >= 0; i--) clock_bit(data[i]);
        clock_bit(1'b0);
        if (bus.bus_busy !== 1'b1) begin
            errors++; $display("FAIL frame_busy: got %b expected 1", bus.bus_busy);
        end
        checks++;
        bus.SDA_sync = 1'b1;
        k = 0;
        do begin step(); k++; end while (bus.stop_det !== 1'b1 && k < 20);
        if (k !== 5) begin
            errors++; $display("FAIL stop_latency: got %0d expected 5", k);
        end
        checks++;
        if (bus.bus_busy !== 1'b1) begin
            errors++; $display("FAIL busy_at_stop: got %b expected 1", bus.bus_busy);
        end
        checks++;
        step();
        if (bus.bus_busy !== 1'b0 || bus.stop_det !== 1'b0) begin
            errors++; $display("FAIL busy_clear: got busy=%b stop=%b expected 0 0", bus.bus_busy, bus.stop_det);
        end
        checks++;
        steps(4);
        if (n_start !== 1 || n_rise !== 9 || n_fall !== 9 || n_stop !== 1 || n_rstart !== 0 || n_arb !== 0) begin
            errors++; $display("FAIL frame_counts: got start=%0d rise=%0d fall=%0d stop=%0d rstart=%0d arb=%0d expected 1 9 9 1 0 0",
                               n_start, n_rise, n_fall, n_stop, n_rstart, n_arb);
        end
        checks++;
    endtask

    task automatic test_rstart();
        int k;
        go_start();
        clock_bit(1'b1);
        clear_counts();
        bus.SDA_sync = 1'b0;
        k = 0;
        do begin step(); k++; end while (bus.start_det !== 1'b1 && bus.rstart_det !== 1'b1 && k < 20);
        if (bus.rstart_det !== 1'b1 || bus.start_det !== 1'b0) begin
            errors++; $display("FAIL rstart_det: got rstart=%b start=%b expected 1 0", bus.rstart_det, bus.start_det);
        end
        checks++;
        steps(3);
        if (bus.bus_busy !== 1'b1 || n_start !== 0 || n_rstart !== 1) begin
            errors++; $display("FAIL rstart_busy: got busy=%b start=%0d rstart=%0d expected 1 0 1", bus.bus_busy, n_start, n_rstart);
        end
        checks++;
        go_stop();
        if (bus.bus_busy !== 1'b0) begin
            errors++; $display("FAIL rstart_stop: got busy=%b expected 0", bus.bus_busy);
        end
        checks++;
    endtask

    task automatic test_arbitration();
        int k;
        go_start();
        bus.master_active = 1'b1;
        bus.SDA_out = 1'b1;
        clear_counts();
        bus.SCL_sync = 1'b0;
        steps(8);
        bus.SCL_sync = 1'b1;
        k = 0;
        do begin step(); k++; end while (bus.scl_rise !== 1'b1 && k < 20);
        if (bus.arb_lost !== 1'b1) begin
            errors++; $display("FAIL arb_at_rise: got %b expected 1", bus.arb_lost);
        end
        checks++;
        step();
        if (bus.arb_lost !== 1'b0) begin
            errors++; $display("FAIL arb_one_cycle: got %b expected 0", bus.arb_lost);
        end
        checks++;
        steps(6);
        bus.SDA_out = 1'b0;
        bus.SCL_sync = 1'b0;
        steps(8);
        bus.SCL_sync = 1'b1;
        k = 0;
        do begin step(); k++; end while (bus.scl_rise !== 1'b1 && k < 20);
        if (bus.arb_lost !== 1'b0 || n_arb !== 1) begin
            errors++; $display("FAIL arb_driven_low: got arb=%b count=%0d expected 0 1", bus.arb_lost, n_arb);
        end
        checks++;
        steps(6);
        // Foreign STOP while we still drive SDA low
        clear_counts();
        go_stop();
        if (n_arb !== 1 || n_stop !== 1) begin
            errors++; $display("FAIL arb_foreign_stop: got arb=%0d stop=%0d expected 1 1", n_arb, n_stop);
        end
        checks++;
        bus.master_active = 1'b0;
        bus.SDA_out = 1'b1;
    endtask

    task automatic test_timeout();
        int k;
        bus.timeout_limit = 16'd100;
        go_start();
        clear_counts();
        bus.SCL_sync = 1'b0;
        k = 0;
        do begin step(); k++; end while (bus.scl_fall !== 1'b1 && k < 20);
        k = 0;
        step(); k++;
        if (bus.scl_stretch !== 1'b1) begin
            errors++; $display("FAIL stretch_set: got %b expected 1", bus.scl_stretch);
        end
        checks++;
        while (bus.bus_timeout !== 1'b1 && k < 200) begin step(); k++; end
        if (k !== 99) begin
            errors++; $display("FAIL timeout_cycle: got %0d expected 99", k);
        end
        checks++;
        step();
        if (bus.bus_busy !== 1'b0 || bus.bus_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_busy: got busy=%b tmo=%b expected 0 0", bus.bus_busy, bus.bus_timeout);
        end
        checks++;
        steps(50);
        if (n_timeout !== 1) begin
            errors++; $display("FAIL timeout_once: got %0d expected 1", n_timeout);
        end
        checks++;
        bus.SCL_sync = 1'b1;
        steps(8);
        if (bus.scl_stretch !== 1'b0) begin
            errors++; $display("FAIL stretch_clear: got %b expected 0", bus.scl_stretch);
        end
        checks++;
        bus.SDA_sync = 1'b1;
        steps(8);
        // Disabled timeout
        bus.timeout_limit = 16'd0;
        go_start();
        clear_counts();
        bus.SCL_sync = 1'b0;
        steps(150);
        if (n_timeout !== 0 || bus.bus_busy !== 1'b1) begin
            errors++; $display("FAIL timeout_disabled: got tmo=%0d busy=%b expected 0 1", n_timeout, bus.bus_busy);
        end
        checks++;
        bus.SCL_out = 1'b0;
        steps(2);
        if (bus.scl_stretch !== 1'b0) begin
            errors++; $display("FAIL stretch_own_low: got %b expected 0", bus.scl_stretch);
        end
        checks++;
        bus.SCL_out = 1'b1;
        bus.SCL_sync = 1'b1;
        steps(8);
        bus.SDA_sync = 1'b1;
        steps(8);
        if (bus.bus_busy !== 1'b0) begin
            errors++; $display("FAIL timeout_final_stop: got busy=%b expected 0", bus.bus_busy);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        go_start();
        clock_bit(1'b1);
        bus.SCL_sync = 1'b0;
        bus.SDA_sync = 1'b0;
        steps(6);
        if (bus.bus_busy !== 1'b1 || bus.SCL_filt !== 1'b0) begin
            errors++; $display("FAIL midframe_pre: got busy=%b scl=%b expected 1 0", bus.bus_busy, bus.SCL_filt);
        end
        checks++;
        #2;
        n_rst = 1'b0;
        #1;
        if (out_vec() !== 11'b110_0000_0000) begin
            errors++; $display("FAIL midframe_reset: got %b expected %b", out_vec(), 11'b110_0000_0000);
        end
        checks++;
        bus.SDA_sync = 1'b1;
        bus.SCL_sync = 1'b1;
        steps(3);
        n_rst = 1'b1;
        clear_counts();
        steps(20);
        if (n_stop !== 0 || n_start !== 0 || out_vec() !== 11'b110_0000_0000) begin
            errors++; $display("FAIL post_reset_quiet: got stop=%0d start=%0d outs=%b expected 0 0 %b",
                               n_stop, n_start, out_vec(), 11'b110_0000_0000);
        end
        checks++;
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_rst             = 1'b0;
        bus.SDA_sync      = 1'b1;
        bus.SCL_sync      = 1'b1;
        bus.SDA_out       = 1'b1;
        bus.SCL_out       = 1'b1;
        bus.master_active = 1'b0;
        bus.timeout_limit = 16'd0;
        clear_counts();
        #23;
        test_reset();
        test_glitch();
        test_frame();
        test_rstart();
        test_arbitration();
        test_timeout();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
